// File: rtl/ram_read_checker_if.sv
// RAM port bundle between the read-back checker and the single-port RAM.
//
// Parameters:
//   DWIDTH - data word width
//   AWIDTH - RAM address width
// Signals:
//   ram_wr_en   - RAM write enable (checker drives it low)
//   ram_addr    - RAM address
//   ram_rd_data - RAM read data
// Modports:
//   master - checker side (drives address/write enable, receives read data)
//   slave  - RAM side
interface ram_read_checker_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 8
);
    logic              ram_wr_en;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_rd_data;

    modport master (
        output ram_wr_en,
        output ram_addr,
        input  ram_rd_data
    );

    modport slave (
        input  ram_wr_en,
        input  ram_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_read_checker.sv
// Sequential read-back engine for a single-port RAM. On start it sweeps addresses
// 0..DEPTH-1, compares each returned word with (seed + addr) mod 2^DWIDTH and
// reports pass/fail, a mismatch count and optionally the first failing address.
//
// Optional feature macro: RAM_CHECK_FIRST_ERR_EN
//   defined   - first_err_addr captures the address of the first mismatch
//   undefined - first_err_addr is tied to 0 and its capture logic is absent
//
// Parameters:
//   DWIDTH     - data word width
//   DEPTH      - words to check, 1 <= DEPTH <= 2^AWIDTH
//   AWIDTH     - RAM address width
//   RD_LATENCY - cycles from address presented to read data valid (>= 1)
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-high reset
//   start          - begin a sweep (sampled only when idle)
//   abort          - cancel the sweep in progress, no done pulse
//   seed           - expected value at address 0, captured on start
//   ram            - RAM port (master modport)
//   busy           - sweep in progress
//   done           - one-cycle pulse at sweep completion
//   pass           - last completed sweep had zero mismatches
//   err_count      - mismatches in the last or current sweep
//   first_err_addr - address of the first mismatch
module ram_read_checker #(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AWIDTH     = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DWIDTH-1:0]   seed,
    ram_read_checker_if.master  ram,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [AWIDTH:0]     err_count,
    output logic [AWIDTH-1:0]   first_err_addr
);

    localparam logic [AWIDTH-1:0] LastAddr  = AWIDTH'(DEPTH - 1);
    localparam int unsigned       CntW      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CntW-1:0]   LastDrain = CntW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [CntW-1:0]   drain_cnt_q;
    logic [DWIDTH-1:0] seed_q;
    logic              done_q;
    logic              pass_q;
    logic [AWIDTH:0]   err_q;

    // Compare pipeline: stage i holds the address issued i+1 cycles ago.
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [AWIDTH-1:0]     pipe_addr_q [RD_LATENCY];

    logic              start_acc;
    logic              abort_act;
    logic [DWIDTH-1:0] exp_data;
    logic              cmp_err;

    assign start_acc = (state_q == StIdle) && start;
    assign abort_act = (state_q != StIdle) && abort;
    assign exp_data  = seed_q + DWIDTH'(pipe_addr_q[RD_LATENCY-1]);
    // An abort edge discards the compare that would land on it as well.
    assign cmp_err   = pipe_vld_q[RD_LATENCY-1] && !abort_act && (ram.ram_rd_data != exp_data);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead:  if (addr_q == LastAddr) state_d = StDrain;
            StDrain: if (drain_cnt_q == LastDrain) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_act) begin
            state_d = StIdle;
        end
    end

    // Outputs; everything except busy comes straight from a register.
    always_comb begin
        busy          = (state_q != StIdle);
        done          = done_q;
        pass          = pass_q;
        err_count     = err_q;
        ram.ram_wr_en = 1'b0;
        ram.ram_addr  = addr_q;
    end

    // Sweep datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            drain_cnt_q <= '0;
            seed_q      <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            pipe_vld_q  <= '0;
        end else begin
            done_q <= (state_q == StDone) && !abort_act;

            pipe_vld_q[0] <= (state_q == StRead) && !abort_act;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1] && !abort_act;
            end

            if (state_q == StDrain) begin
                drain_cnt_q <= drain_cnt_q + 1'b1;
            end else begin
                drain_cnt_q <= '0;
            end

            // Address holds at the last word so it never wraps within a sweep.
            if (state_q == StRead && !abort_act && addr_q != LastAddr) begin
                addr_q <= addr_q + 1'b1;
            end

            if (cmp_err) begin
                err_q <= err_q + 1'b1;
            end

            if (state_q == StDone && !abort_act) begin
                pass_q <= (err_q == '0);
            end

            if (start_acc) begin
                seed_q <= seed;
                addr_q <= '0;
                err_q  <= '0;
                pass_q <= 1'b0;
            end
        end
    end

    // Address shift chain needs no reset; the valid bits gate its use.
    always_ff @(posedge clk) begin
        pipe_addr_q[0] <= addr_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_addr_q[i] <= pipe_addr_q[i-1];
        end
    end

`ifdef RAM_CHECK_FIRST_ERR_EN
    logic [AWIDTH-1:0] first_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_q <= '0;
        end else if (start_acc) begin
            first_err_q <= '0;
        end else if (cmp_err && err_q == '0) begin
            first_err_q <= pipe_addr_q[RD_LATENCY-1];
        end
    end

    assign first_err_addr = first_err_q;
`else
    assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_ram_read_checker.sv
// Self-checking bench for ram_read_checker. Two instances: defaults (DEPTH 256,
// latency 1) and a small one (DEPTH 16, latency 2). A behavioural model derives
// every output from the sweep start edge, abort/reset edges and the list of bad
// words; a compare process checks both DUTs on every cycle.
module tb_ram_read_checker;

    localparam int D0  = 256;
    localparam int L0  = 1;
    localparam int D1  = 16;
    localparam int L1  = 2;
    localparam int INF = 1 << 30;
`ifdef RAM_CHECK_FIRST_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst, start, abort;
    logic [1:0][7:0] seed;
    logic [1:0]      busy, done, pass, wr_en;
    logic [1:0][8:0] errc;
    logic [1:0][7:0] ferr, addr;
    logic [7:0]      mem [2][256];
    logic [7:0]      a1;

    ram_read_checker_if #(.DWIDTH(8), .AWIDTH(8)) bus0 ();
    ram_read_checker_if #(.DWIDTH(8), .AWIDTH(8)) bus1 ();

    ram_read_checker #(.DWIDTH(8), .DEPTH(D0), .AWIDTH(8), .RD_LATENCY(L0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]), .seed(seed[0]),
        .ram(bus0), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .first_err_addr(ferr[0])
    );

    ram_read_checker #(.DWIDTH(8), .DEPTH(D1), .AWIDTH(8), .RD_LATENCY(L1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]), .seed(seed[1]),
        .ram(bus1), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .first_err_addr(ferr[1])
    );

    assign wr_en[0] = bus0.ram_wr_en;
    assign wr_en[1] = bus1.ram_wr_en;
    assign addr[0]  = bus0.ram_addr;
    assign addr[1]  = bus1.ram_addr;

    // RAM models: latency 1 and latency 2.
    always @(posedge clk) bus0.ram_rd_data <= mem[0][bus0.ram_addr];
    always @(posedge clk) begin
        a1                <= bus1.ram_addr;
        bus1.ram_rd_data  <= mem[1][a1];
    end

    // ---------------- behavioural model ----------------
    int ecnt = 0;
    int s_e [2] = '{-1, -1};
    int ab_e[2] = '{INF, INF};
    bit mis [2][256];
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    function automatic int dep(input int d);
        return (d == 0) ? D0 : D1;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    // Sweep of DUT d is still running when edge e arrives.
    function automatic bit nonidle(input int d, input int e);
        return s_e[d] >= 0 && e > s_e[d] && e <= s_e[d] + dep(d) + lat(d) + 1 && ab_e[d] >= e;
    endfunction

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                s_e[d]  <= -1;
                ab_e[d] <= INF;
            end else if (start[d] && !nonidle(d, ecnt + 1)) begin
                s_e[d]  <= ecnt + 1;
                ab_e[d] <= INF;
                for (int k = 0; k < 256; k++) begin
                    mis[d][k] <= (k < dep(d)) && (mem[d][k] != 8'(seed[d] + k));
                end
            end else if (abort[d] && nonidle(d, ecnt + 1)) begin
                ab_e[d] <= ecnt + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int s, ab, fin, c, e_busy, e_done, e_pass, e_cnt, e_first;
                s = s_e[d]; ab = ab_e[d]; fin = s + dep(d) + lat(d) + 1;
                e_busy = 0; e_done = 0; e_pass = 0; e_cnt = 0; e_first = -1;
                if (s >= 0) begin
                    e_busy = (ecnt >= s && ecnt < fin && ecnt < ab) ? 1 : 0;
                    e_done = (ecnt == fin && ab > fin) ? 1 : 0;
                    for (int k = 0; k < dep(d); k++) begin
                        c = s + k + lat(d) + 1;
                        if (mis[d][k] && c <= ecnt && c < ab) begin
                            e_cnt++;
                            if (e_first < 0) e_first = k;
                        end
                    end
                    e_pass = (ecnt >= fin && ab > fin && e_cnt == 0) ? 1 : 0;
                end
                if (e_first < 0 || !FE) e_first = 0;
                chk($sformatf("busy%0d", d), int'(busy[d]), e_busy);
                chk($sformatf("done%0d", d), int'(done[d]), e_done);
                chk($sformatf("pass%0d", d), int'(pass[d]), e_pass);
                chk($sformatf("err_count%0d", d), int'(errc[d]), e_cnt);
                chk($sformatf("first_err_addr%0d", d), int'(ferr[d]), e_first);
                chk($sformatf("ram_wr_en%0d", d), int'(wr_en[d]), 0);
                if (e_busy == 1) begin
                    chk($sformatf("ram_addr%0d", d), int'(addr[d]),
                        (ecnt - s < dep(d) - 1) ? ecnt - s : dep(d) - 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_edge(input int x);
        while (ecnt < x) @(negedge clk);
    endtask

    task automatic fill(input int d, input logic [7:0] s);
        for (int i = 0; i < 256; i++) mem[d][i] = 8'(s + i);
    endtask

    // Returns at the negedge after the sampling edge; that edge is ecnt.
    task automatic pulse_start(input int d, input logic [7:0] s);
        seed[d]  = s;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    initial begin
        int s0, d, tot, mode, ev;
        rst = 2'b11; start = '0; abort = '0; seed = '0;
        fill(0, 8'h00); fill(1, 8'h00);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 2'b00;
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_err_count", int'(errc[0]), 0);
        chk("reset_ram_addr", int'(addr[0]), 0);
        chk("reset_pass", int'(pass[0]), 0);

        // Clean sweep, seed 1.
        fill(0, 8'h01);
        pulse_start(0, 8'h01); s0 = ecnt;
        wait_edge(s0 + 5);
        chk("t1_addr_at_5", int'(addr[0]), 5);
        wait_edge(s0 + 257);
        chk("t1_done_early", int'(done[0]), 0);
        chk("t1_busy_257", int'(busy[0]), 1);
        wait_edge(s0 + 258);
        chk("t1_done_258", int'(done[0]), 1);
        chk("t1_pass", int'(pass[0]), 1);
        chk("t1_busy_258", int'(busy[0]), 0);

        // Back-to-back start with two corrupted words.
        mem[0][8'h10] = 8'hFF; mem[0][8'hA0] = 8'h00;
        pulse_start(0, 8'h01); s0 = ecnt;
        chk("t2_b2b_accept", int'(busy[0]), 1);
        wait_edge(s0 + 258);
        chk("t2_done", int'(done[0]), 1);
        chk("t2_pass", int'(pass[0]), 0);
        chk("t2_err_count", int'(errc[0]), 2);
        chk("t2_first_err", int'(ferr[0]), FE ? 16 : 0);

        // Data wrap 0xFF -> 0x00.
        fill(0, 8'hF0);
        wait_edge(s0 + 262);
        pulse_start(0, 8'hF0); s0 = ecnt;
        wait_edge(s0 + 258);
        chk("t3_pass", int'(pass[0]), 1);
        chk("t3_err_count", int'(errc[0]), 0);

        // Abort sampled at edge 101 with one bad word at address 5.
        mem[0][5] = 8'h00;
        wait_edge(s0 + 262);
        pulse_start(0, 8'hF0); s0 = ecnt;
        wait_edge(s0 + 100);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("t4_busy_after_abort", int'(busy[0]), 0);
        chk("t4_partial_err", int'(errc[0]), 1);
        chk("t4_pass", int'(pass[0]), 0);
        wait_edge(s0 + 300);
        mem[0][5] = 8'hF5;
        pulse_start(0, 8'hF0); s0 = ecnt;
        wait_edge(s0 + 258);
        chk("t4_clean_done", int'(done[0]), 1);
        chk("t4_clean_pass", int'(pass[0]), 1);

        // Start while busy is ignored.
        wait_edge(s0 + 262);
        pulse_start(0, 8'hF0); s0 = ecnt;
        wait_edge(s0 + 29);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_edge(s0 + 258);
        chk("t5_done_timing", int'(done[0]), 1);

        // Reset at edge 50 of a sweep that already saw a mismatch.
        mem[0][5] = 8'h00;
        wait_edge(s0 + 262);
        pulse_start(0, 8'hF0); s0 = ecnt;
        wait_edge(s0 + 49);
        chk("t6_err_before_rst", int'(errc[0]), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("t6_busy_rst", int'(busy[0]), 0);
        chk("t6_err_rst", int'(errc[0]), 0);
        chk("t6_addr_rst", int'(addr[0]), 0);
        chk("t6_first_rst", int'(ferr[0]), 0);
        mem[0][5] = 8'hF5;

        // Small instance: latency 2, depth 16.
        fill(1, 8'h3C);
        pulse_start(1, 8'h3C); s0 = ecnt;
        wait_edge(s0 + 18);
        chk("t7_done_early", int'(done[1]), 0);
        wait_edge(s0 + 19);
        chk("t7_done_19", int'(done[1]), 1);
        chk("t7_pass", int'(pass[1]), 1);

        // Randomized sweeps with optional abort, reset or stray start.
        for (int it = 0; it < 16; it++) begin
            d = $urandom_range(0, 1);
            fill(d, 8'($urandom));
            for (int n = $urandom_range(0, 3); n > 0; n--) begin
                ev = $urandom_range(0, dep(d) - 1);
                mem[d][ev] = mem[d][ev] ^ 8'($urandom_range(1, 255));
            end
            pulse_start(d, mem[d][0]);
            tot  = dep(d) + lat(d) + 1;
            mode = $urandom_range(0, 3);
            ev   = $urandom_range(1, tot);
            for (int c = 1; c <= tot + 2; c++) begin
                if (c == ev && mode == 1) abort[d] = 1'b1;
                if (c == ev && mode == 2) rst[d] = 1'b1;
                if (c == ev && mode == 3) start[d] = 1'b1;
                @(negedge clk);
                abort[d] = 1'b0; rst[d] = 1'b0; start[d] = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
